// File: rtl/qbus_pkg.sv
// Shared QBUS master definitions: cycle-engine states and default bus timing in qclk cycles.
package qbus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_AHOLD,
        ST_RWAIT,
        ST_RSKEW,
        ST_WSETUP,
        ST_WWAIT,
        ST_WSKEW,
        ST_WHOLD,
        ST_RNEG,
        ST_ABORT,
        ST_DONE
    } qbus_state_e;

    // Defaults assume a 20 MHz qclk.
    localparam int unsigned QB_ADDR_SETUP  = 3;
    localparam int unsigned QB_ADDR_HOLD   = 2;
    localparam int unsigned QB_DATA_SETUP  = 2;
    localparam int unsigned QB_RPLY_DESKEW = 3;
    localparam int unsigned QB_DATA_HOLD   = 2;
    localparam int unsigned QB_TIMEOUT     = 200;

endpackage

// File: rtl/qbus_delay.sv
// Loadable saturating down-counter; zero_o flags that the loaded interval has elapsed.
module qbus_delay #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/qbus_master.sv
// QBUS bus-master cycle engine: runs one DATI, DATO or DATOB per accepted request,
// driving TSYNC/TDIN/TDOUT and the Am2908 DAL transceiver controls, with NXM timeout.
module qbus_master
    import qbus_pkg::*;
#(
    parameter int unsigned ADDR_SETUP  = QB_ADDR_SETUP,
    parameter int unsigned ADDR_HOLD   = QB_ADDR_HOLD,
    parameter int unsigned DATA_SETUP  = QB_DATA_SETUP,
    parameter int unsigned RPLY_DESKEW = QB_RPLY_DESKEW,
    parameter int unsigned DATA_HOLD   = QB_DATA_HOLD,
    parameter int unsigned TIMEOUT     = QB_TIMEOUT
) (
    input  logic        qclk,
    input  logic        reset,
    input  logic        RINIT,
    input  logic        req,
    input  logic [21:0] addr,
    input  logic        bs7,
    input  logic        write,
    input  logic        byte_i,   // "byte" is a reserved word in SystemVerilog
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        nxm,
    output logic [15:0] rdata,
    output logic        DALtx,
    output logic        DALst,
    output logic        DALbe_L,
    inout  logic [21:0] ZDAL,
    output logic        ZBS7,
    output logic        ZWTBT,
    output logic        TSYNC,
    output logic        TDIN,
    output logic        TDOUT,
    input  logic        RRPLY
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    qbus_state_e state_q, state_d;
    logic        tsync_q, tsync_d, tdin_q, tdin_d, tdout_q, tdout_d;
    logic        daltx_q, daltx_d, dalst_q, dalst_d, dalbe_l_q, dalbe_l_d;
    logic        zbs7_q, zbs7_d, zwtbt_q, zwtbt_d;
    logic        busy_q, busy_d, done_q, done_d, nxm_q, nxm_d, pend_q;
    logic [21:0] zdal_q, zdal_d;
    logic [15:0] rdata_q, rdata_d, wdata_q, wdata_d;
    logic        write_q, write_d, byte_q, byte_d;
    logic        dly_load, dly_zero, go_abort;
    logic [CW-1:0] dly_val;
    logic        unused_dal_hi;

    qbus_delay #(.W(CW)) u_dly (
        .clk_i      (qclk),
        .reset_i    (reset),
        .load_i     (dly_load),
        .load_val_i (dly_val),
        .zero_o     (dly_zero)
    );

    always_comb begin
        state_d   = state_q;
        tsync_d   = tsync_q;
        tdin_d    = tdin_q;
        tdout_d   = tdout_q;
        daltx_d   = daltx_q;
        dalst_d   = 1'b0;
        dalbe_l_d = dalbe_l_q;
        zbs7_d    = zbs7_q;
        zwtbt_d   = zwtbt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        nxm_d     = nxm_q;
        zdal_d    = zdal_q;
        rdata_d   = rdata_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        byte_d    = byte_q;
        dly_load  = 1'b0;
        dly_val   = '0;
        go_abort  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A cycle killed by RINIT still owes the requester a done/nxm pulse.
                if (pend_q) begin
                    done_d  = 1'b1;
                    nxm_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (req) begin
                    busy_d   = 1'b1;
                    nxm_d    = 1'b0;
                    write_d  = write;
                    byte_d   = byte_i;
                    wdata_d  = wdata;
                    zdal_d   = addr;
                    zbs7_d   = bs7;
                    zwtbt_d  = write;
                    daltx_d  = 1'b1;
                    dalst_d  = 1'b1;
                    dly_load = 1'b1;
                    dly_val  = CW'(ADDR_SETUP - 1);
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                dalbe_l_d = 1'b0;
                if (dly_zero) begin
                    tsync_d  = 1'b1;
                    dly_load = 1'b1;
                    dly_val  = CW'(ADDR_HOLD - 1);
                    state_d  = ST_AHOLD;
                end
            end
            ST_AHOLD: begin
                if (dly_zero) begin
                    dly_load = 1'b1;
                    zbs7_d   = 1'b0;
                    if (write_q) begin
                        zdal_d  = {6'b0, wdata_q};
                        dalst_d = 1'b1;
                        zwtbt_d = byte_q;
                        dly_val = CW'(DATA_SETUP - 1);
                        state_d = ST_WSETUP;
                    end else begin
                        daltx_d   = 1'b0;
                        dalbe_l_d = 1'b1;
                        zwtbt_d   = 1'b0;
                        tdin_d    = 1'b1;
                        dly_val   = CW'(TIMEOUT - 1);
                        state_d   = ST_RWAIT;
                    end
                end
            end
            ST_RWAIT: begin
                if (RRPLY) begin
                    dly_load = 1'b1;
                    dly_val  = CW'(RPLY_DESKEW - 1);
                    state_d  = ST_RSKEW;
                end else if (dly_zero) begin
                    go_abort = 1'b1;
                end
            end
            ST_RSKEW: begin
                if (dly_zero) begin
                    rdata_d  = ZDAL[15:0];
                    tdin_d   = 1'b0;
                    dly_load = 1'b1;
                    dly_val  = CW'(TIMEOUT - 1);
                    state_d  = ST_RNEG;
                end
            end
            ST_WSETUP: begin
                if (dly_zero) begin
                    tdout_d  = 1'b1;
                    dly_load = 1'b1;
                    dly_val  = CW'(TIMEOUT - 1);
                    state_d  = ST_WWAIT;
                end
            end
            ST_WWAIT: begin
                if (RRPLY) begin
                    dly_load = 1'b1;
                    dly_val  = CW'(RPLY_DESKEW - 1);
                    state_d  = ST_WSKEW;
                end else if (dly_zero) begin
                    go_abort = 1'b1;
                end
            end
            ST_WSKEW: begin
                if (dly_zero) begin
                    tdout_d  = 1'b0;
                    dly_load = 1'b1;
                    dly_val  = CW'(DATA_HOLD - 1);
                    state_d  = ST_WHOLD;
                end
            end
            ST_WHOLD: begin
                if (dly_zero) begin
                    daltx_d   = 1'b0;
                    dalbe_l_d = 1'b1;
                    zwtbt_d   = 1'b0;
                    dly_load  = 1'b1;
                    dly_val   = CW'(TIMEOUT - 1);
                    state_d   = ST_RNEG;
                end
            end
            ST_RNEG: begin
                // A stuck RPLY does not make the transfer fail; TSYNC is simply released.
                if (!RRPLY || dly_zero) begin
                    tsync_d = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_ABORT: begin
                done_d  = 1'b1;
                nxm_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_abort) begin
            tdin_d    = 1'b0;
            tdout_d   = 1'b0;
            tsync_d   = 1'b0;
            daltx_d   = 1'b0;
            dalbe_l_d = 1'b1;
            zbs7_d    = 1'b0;
            zwtbt_d   = 1'b0;
            state_d   = ST_ABORT;
        end
    end

    always_ff @(posedge qclk) begin
        if (reset || RINIT) begin
            state_q   <= ST_IDLE;
            tsync_q   <= 1'b0;
            tdin_q    <= 1'b0;
            tdout_q   <= 1'b0;
            daltx_q   <= 1'b0;
            dalst_q   <= 1'b0;
            dalbe_l_q <= 1'b1;
            zbs7_q    <= 1'b0;
            zwtbt_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            nxm_q     <= 1'b0;
            pend_q    <= !reset && (pend_q || busy_q);
        end else begin
            state_q   <= state_d;
            tsync_q   <= tsync_d;
            tdin_q    <= tdin_d;
            tdout_q   <= tdout_d;
            daltx_q   <= daltx_d;
            dalst_q   <= dalst_d;
            dalbe_l_q <= dalbe_l_d;
            zbs7_q    <= zbs7_d;
            zwtbt_q   <= zwtbt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            nxm_q     <= nxm_d;
            pend_q    <= 1'b0;
        end
    end

    // Datapath registers survive RINIT; only rdata is architecturally defined after reset.
    always_ff @(posedge qclk) begin
        if (reset) begin
            rdata_q <= '0;
            zdal_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            byte_q  <= 1'b0;
        end else if (!RINIT) begin
            rdata_q <= rdata_d;
            zdal_q  <= zdal_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            byte_q  <= byte_d;
        end
    end

    assign ZDAL          = daltx_q ? zdal_q : 'z;
    assign unused_dal_hi = ^ZDAL[21:16];

    assign busy    = busy_q;
    assign done    = done_q;
    assign nxm     = nxm_q;
    assign rdata   = rdata_q;
    assign DALtx   = daltx_q;
    assign DALst   = dalst_q;
    assign DALbe_L = dalbe_l_q;
    assign ZBS7    = zbs7_q;
    assign ZWTBT   = zwtbt_q;
    assign TSYNC   = tsync_q;
    assign TDIN    = tdin_q;
    assign TDOUT   = tdout_q;

endmodule

// File: tb/tb_qbus_master.sv
// Directed bench for qbus_master with a cycle-stepped QBUS slave model sampled on the falling edge.
module tb_qbus_master;

    logic        qclk = 1'b0;
    logic        reset, RINIT, req, bs7, write, byte_i, RRPLY;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic        busy, done, nxm, DALtx, DALst, DALbe_L, ZBS7, ZWTBT, TSYNC, TDIN, TDOUT;
    logic [15:0] rdata;
    wire  [21:0] zdal;

    logic        slv_en, slv_drive;
    logic [21:0] slv_dal, slv_addr;
    logic [15:0] slv_rdata, slv_wdata;
    logic        slv_wtbt;
    int          slv_hold, slv_hcnt;

    int          checks = 0;
    int          errors = 0;

    int          cyc, t_dal, t_be, t_data_st, t_tsync_rise, t_tsync_fall;
    int          t_tdin_rise, t_tdin_fall, t_tdout_rise, t_rply_fall, t_done;
    logic [21:0] dal_addr;
    logic [15:0] dal_data, done_rdata;
    logic        bs7_addr, wtbt_addr, bs7_data, wtbt_data, done_nxm, busy1;
    logic [5:0]  done_idle;

    assign zdal = slv_drive ? slv_dal : 'z;

    always #5 qclk = ~qclk;

    qbus_master dut (
        .qclk    (qclk),
        .reset   (reset),
        .RINIT   (RINIT),
        .req     (req),
        .addr    (addr),
        .bs7     (bs7),
        .write   (write),
        .byte_i  (byte_i),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .nxm     (nxm),
        .rdata   (rdata),
        .DALtx   (DALtx),
        .DALst   (DALst),
        .DALbe_L (DALbe_L),
        .ZDAL    (zdal),
        .ZBS7    (ZBS7),
        .ZWTBT   (ZWTBT),
        .TSYNC   (TSYNC),
        .TDIN    (TDIN),
        .TDOUT   (TDOUT),
        .RRPLY   (RRPLY)
    );

    task automatic start(input logic [21:0] a, input logic b7, input logic wr,
                         input logic bt, input logic [15:0] wd);
        @(negedge qclk);
        addr = a; bs7 = b7; write = wr; byte_i = bt; wdata = wd;
        req = 1'b1;
    endtask

    // Steps one falling edge at a time until done, logging event cycles and playing the slave.
    task automatic run(input int max_cyc, input int rinit_at, input int req_at);
        logic p_tsync, p_tdin;
        bit   seen;
        cyc = 0; t_dal = 0; t_be = 0; t_data_st = 0; t_tsync_rise = 0; t_tsync_fall = 0;
        t_tdin_rise = 0; t_tdin_fall = 0; t_tdout_rise = 0; t_rply_fall = 0; t_done = 0;
        busy1 = 1'b0; done_nxm = 1'bx; done_rdata = 'x; done_idle = 'x;
        p_tsync = TSYNC; p_tdin = TDIN; seen = 0;
        while (!seen && cyc < max_cyc) begin
            @(negedge qclk);
            cyc++;
            req   = (cyc == req_at);
            RINIT = (cyc == rinit_at);
            if (cyc == 1) busy1 = busy;
            if (DALst) begin
                if (t_dal == 0) begin
                    t_dal = cyc; dal_addr = zdal; bs7_addr = ZBS7; wtbt_addr = ZWTBT;
                end else if (t_data_st == 0) begin
                    t_data_st = cyc; dal_data = zdal[15:0]; bs7_data = ZBS7; wtbt_data = ZWTBT;
                end
            end
            if (!DALbe_L && t_be == 0) t_be = cyc;
            if (TSYNC && !p_tsync) begin t_tsync_rise = cyc; slv_addr = zdal; end
            if (!TSYNC && p_tsync) t_tsync_fall = cyc;
            if (TDIN && !p_tdin) t_tdin_rise = cyc;
            if (!TDIN && p_tdin) t_tdin_fall = cyc;
            if (TDOUT && t_tdout_rise == 0) t_tdout_rise = cyc;
            p_tsync = TSYNC; p_tdin = TDIN;
            if (done) begin
                seen = 1; t_done = cyc; done_nxm = nxm; done_rdata = rdata;
                done_idle = {TSYNC, TDIN, TDOUT, DALtx, DALbe_L, busy};
            end
            if (slv_en && (TDIN || TDOUT) && !RRPLY) begin
                RRPLY = 1'b1; slv_hcnt = slv_hold;
                if (TDIN) begin
                    slv_drive = 1'b1; slv_dal = {6'b0, slv_rdata};
                end else begin
                    slv_wdata = zdal[15:0]; slv_wtbt = ZWTBT;
                end
            end else if (RRPLY && !TDIN && !TDOUT) begin
                if (slv_hcnt == 0) begin
                    RRPLY = 1'b0; slv_drive = 1'b0; t_rply_fall = cyc;
                end else begin
                    slv_hcnt--;
                end
            end
        end
        req = 1'b0; RINIT = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; RINIT = 1'b0; req = 1'b0; RRPLY = 1'b0;
        addr = '0; bs7 = 1'b0; write = 1'b0; byte_i = 1'b0; wdata = '0;
        slv_en = 1'b0; slv_drive = 1'b0; slv_dal = '0; slv_hold = 0; slv_hcnt = 0;
        repeat (3) @(negedge qclk);
        checks++;
        if ({TSYNC, TDIN, TDOUT, DALtx, DALst, DALbe_L, ZBS7, ZWTBT} !== 8'b0000_0100) begin
            errors++;
            $display("FAIL reset_bus: got %b want 00000100",
                     {TSYNC, TDIN, TDOUT, DALtx, DALst, DALbe_L, ZBS7, ZWTBT});
        end
        checks++;
        if ({busy, done, nxm} !== 3'b000) begin
            errors++; $display("FAIL reset_status: got %b want 000", {busy, done, nxm});
        end
        checks++;
        if (rdata !== 16'h0000) begin
            errors++; $display("FAIL reset_rdata: got %h want 0000", rdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_dati();
        slv_en = 1'b1; slv_hold = 3; slv_rdata = 16'o177777;
        start(22'o777570, 1'b1, 1'b0, 1'b0, 16'h0000);
        run(60, 0, 0);
        checks++;
        if ({busy1, bs7_addr, wtbt_addr, dal_addr} !== {1'b1, 1'b1, 1'b0, 22'o777570}) begin
            errors++; $display("FAIL dati_addr_phase: got %b %b %b %o want 1 1 0 777570",
                               busy1, bs7_addr, wtbt_addr, dal_addr);
        end
        checks++;
        if (t_dal !== 1 || t_be !== 2) begin
            errors++; $display("FAIL dati_dalst_be: got st@%0d be@%0d want st@1 be@2", t_dal, t_be);
        end
        checks++;
        if (t_tsync_rise - t_dal !== 3) begin
            errors++; $display("FAIL dati_addr_setup: got %0d want 3", t_tsync_rise - t_dal);
        end
        checks++;
        if (t_tdin_rise !== 6 || t_tdin_fall !== 10) begin
            errors++; $display("FAIL dati_tdin: got %0d..%0d want 6..10", t_tdin_rise, t_tdin_fall);
        end
        checks++;
        if (done_rdata !== 16'o177777 || done_nxm !== 1'b0) begin
            errors++; $display("FAIL dati_data: got %o nxm=%b want 177777 nxm=0", done_rdata, done_nxm);
        end
        checks++;
        if (t_rply_fall !== 13 || t_tsync_fall !== 14 || t_done !== 14) begin
            errors++; $display("FAIL dati_tsync_after_rply: got rply@%0d tsync@%0d done@%0d want 13 14 14",
                               t_rply_fall, t_tsync_fall, t_done);
        end
    endtask

    task automatic test_dato();
        slv_en = 1'b1; slv_hold = 0;
        start(22'o000440, 1'b0, 1'b1, 1'b0, 16'o054321);
        run(60, 0, 0);
        checks++;
        if ({wtbt_addr, wtbt_data, bs7_data} !== 3'b100) begin
            errors++; $display("FAIL dato_wtbt: got a=%b d=%b bs7=%b want 1 0 0", wtbt_addr, wtbt_data, bs7_data);
        end
        checks++;
        if (t_data_st !== 6 || dal_data !== 16'o054321) begin
            errors++; $display("FAIL dato_data_phase: got @%0d %o want @6 054321", t_data_st, dal_data);
        end
        checks++;
        if (t_tdout_rise - t_data_st !== 2) begin
            errors++; $display("FAIL dato_data_setup: got %0d want 2", t_tdout_rise - t_data_st);
        end
        checks++;
        if (slv_wdata !== 16'o054321 || slv_addr !== 22'o000440) begin
            errors++; $display("FAIL dato_slave: got %o @%o want 054321 @000440", slv_wdata, slv_addr);
        end
        checks++;
        if (t_done !== 15 || done_nxm !== 1'b0 || done_idle !== 6'b000010) begin
            errors++; $display("FAIL dato_done: got @%0d nxm=%b bus=%b want @15 nxm=0 bus=000010",
                               t_done, done_nxm, done_idle);
        end
    endtask

    task automatic test_datob();
        slv_en = 1'b1; slv_hold = 0;
        start(22'o000441, 1'b0, 1'b1, 1'b1, 16'o000252);
        run(60, 0, 0);
        checks++;
        if ({wtbt_addr, wtbt_data} !== 2'b11) begin
            errors++; $display("FAIL datob_wtbt: got a=%b d=%b want 1 1", wtbt_addr, wtbt_data);
        end
        checks++;
        if ({slv_addr[0], slv_wtbt} !== 2'b11 || slv_wdata !== 16'o000252) begin
            errors++; $display("FAIL datob_slave: got a0=%b wtbt=%b %o want 1 1 000252",
                               slv_addr[0], slv_wtbt, slv_wdata);
        end
        checks++;
        if (t_done !== 15 || done_nxm !== 1'b0) begin
            errors++; $display("FAIL datob_done: got @%0d nxm=%b want @15 nxm=0", t_done, done_nxm);
        end
    endtask

    task automatic test_nxm();
        slv_en = 1'b0;
        start(22'o000400, 1'b0, 1'b0, 1'b0, 16'h0000);
        run(300, 0, 0);
        checks++;
        if (t_tdin_rise !== 6 || t_tdin_fall - t_tdin_rise !== 200) begin
            errors++; $display("FAIL nxm_timeout: got tdin %0d..%0d want 6..206", t_tdin_rise, t_tdin_fall);
        end
        checks++;
        if (t_tsync_fall !== 206 || t_done !== 207) begin
            errors++; $display("FAIL nxm_timing: got tsync@%0d done@%0d want 206 207", t_tsync_fall, t_done);
        end
        checks++;
        if (done_nxm !== 1'b1 || done_idle !== 6'b000010) begin
            errors++; $display("FAIL nxm_flag: got nxm=%b bus=%b want nxm=1 bus=000010", done_nxm, done_idle);
        end
    endtask

    task automatic test_rinit();
        slv_en = 1'b0;
        start(22'o000400, 1'b0, 1'b0, 1'b0, 16'h0000);
        run(60, 10, 0);
        checks++;
        if (t_tsync_fall !== 11 || t_tdin_fall !== 11) begin
            errors++; $display("FAIL rinit_drop: got tsync@%0d tdin@%0d want 11 11", t_tsync_fall, t_tdin_fall);
        end
        checks++;
        if (t_done !== 12 || done_nxm !== 1'b1 || done_idle !== 6'b000010) begin
            errors++; $display("FAIL rinit_done: got @%0d nxm=%b bus=%b want @12 nxm=1 bus=000010",
                               t_done, done_nxm, done_idle);
        end
        slv_en = 1'b1; slv_hold = 0; slv_rdata = 16'o177777;
        start(22'o777570, 1'b1, 1'b0, 1'b0, 16'h0000);
        run(60, 0, 0);
        checks++;
        if (t_done !== 11 || done_nxm !== 1'b0 || done_rdata !== 16'o177777) begin
            errors++; $display("FAIL rinit_recover: got @%0d nxm=%b %o want @11 nxm=0 177777",
                               t_done, done_nxm, done_rdata);
        end
    endtask

    task automatic test_req_while_busy();
        int extra;
        slv_en = 1'b1; slv_hold = 0; slv_rdata = 16'o012345;
        start(22'o777570, 1'b1, 1'b0, 1'b0, 16'h0000);
        run(60, 0, 5);
        checks++;
        if (t_done !== 11 || done_rdata !== 16'o012345) begin
            errors++; $display("FAIL busy_first: got @%0d %o want @11 012345", t_done, done_rdata);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge qclk);
            if (busy || done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL busy_dropped_req: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        slv_en = 1'b1; slv_hold = 0; slv_rdata = 16'o070707;
        start(22'o777570, 1'b1, 1'b0, 1'b0, 16'h0000);
        run(60, 0, 0);
        checks++;
        if (t_done !== 11 || done_rdata !== 16'o070707) begin
            errors++; $display("FAIL b2b_first: got @%0d %o want @11 070707", t_done, done_rdata);
        end
        start(22'o001000, 1'b0, 1'b1, 1'b0, 16'o123456);
        run(60, 0, 0);
        checks++;
        if (busy1 !== 1'b1 || t_dal !== 1) begin
            errors++; $display("FAIL b2b_accept: got busy=%b st@%0d want busy=1 st@1", busy1, t_dal);
        end
        checks++;
        if (t_done !== 15 || slv_wdata !== 16'o123456 || done_nxm !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got @%0d %o nxm=%b want @15 123456 nxm=0",
                               t_done, slv_wdata, done_nxm);
        end
    endtask

    initial begin
        test_reset();
        test_dati();
        test_dato();
        test_datob();
        test_nxm();
        test_rinit();
        test_req_while_busy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qbus_master.md
Name: qbus_master

Overview:
- QBUS bus-master cycle engine inside the FPGA. Given a granted bus, it runs one DATI (read), DATO (word write) or DATOB (byte write) cycle per request.
- Drives TSYNC/TDIN/TDOUT and the Am2908 DAL transceiver controls (DALtx, DALst, DALbe_L, ZDAL, ZBS7, ZWTBT), and watches RRPLY.
- Times out to NXM when no slave replies.
- Sits between the future DMA controller (request side) and qdrv (bus side). It is the initiator counterpart of the slave path in pmo/qsync.

Parameters:
- ADDR_SETUP, 3, qclk cycles address is on DAL before TSYNC asserts (150 ns at 20 MHz).
- ADDR_HOLD, 2, cycles address stays on DAL after TSYNC asserts.
- DATA_SETUP, 2, write data on DAL before TDOUT asserts.
- RPLY_DESKEW, 3, cycles after RRPLY is first seen before read data is latched or TDOUT is negated.
- DATA_HOLD, 2, write data held after TDOUT negates.
- TIMEOUT, 200, cycles with no RRPLY before NXM (10 us).

Ports:
- qclk  in  1  system clock (20 MHz)
- reset  in  1  synchronous, active-high
- RINIT  in  1  bus INIT; aborts the current cycle
- req  in  1  start-cycle pulse; sampled only in IDLE
- addr  in  22  bus address
- bs7  in  1  I/O-page select
- write  in  1  1 = DATO/DATOB, 0 = DATI
- byte  in  1  byte write (DATOB); ignored on reads
- wdata  in  16  write data
- busy  out  1  cycle in progress
- done  out  1  one-cycle completion pulse
- nxm  out  1  valid with done; 1 = no reply (timeout)
- rdata  out  16  read data, valid from done until the next done
- DALtx  out  1  Am2908 direction: 1 = FPGA drives bus
- DALst  out  1  latch-strobe pulse into Am2908 output latches
- DALbe_L  out  1  bus enable, active low
- ZDAL  inout  22  FPGA-side DAL
- ZBS7  out  1  BS7 to driver
- ZWTBT  out  1  WTBT to driver
- TSYNC, TDIN, TDOUT  out  1 each  bus control drives (active high at FPGA)
- RRPLY  in  1  received RPLY

Behaviour:
- Reset or RINIT (synchronous, same cycle): state goes to IDLE. All T*, DALtx, DALst, ZBS7, ZWTBT, busy, done and nxm go to 0. DALbe_L goes to 1 and ZDAL to high-Z. rdata goes to 0 on reset only. If RINIT lands mid-cycle, done fires with nxm=1 on the next cycle.
- req is honoured only in IDLE; a req while busy is dropped.
- addr, bs7, write, byte and wdata are captured on acceptance.
- ZDAL drives only while DALtx=1. Each new value (address or data) is presented with a one-cycle DALst pulse. DALbe_L=0 from the cycle after the first DALst until data is released.
- IDLE -> ADDR on req. busy=1.
- ADDR: ZDAL=addr, ZBS7=bs7, ZWTBT=write. After ADDR_SETUP cycles, assert TSYNC and go to AHOLD.
- AHOLD: hold the address for ADDR_HOLD cycles.
  - On a read: DALtx=0, DALbe_L=1, ZBS7=0, ZWTBT=0, assert TDIN and go to RWAIT.
  - On a write: ZDAL=wdata, ZWTBT=byte, ZBS7=0, go to WSETUP.
- RWAIT: on RRPLY go to RSKEW. If the timeout counter reaches TIMEOUT, go to ABORT.
- RSKEW: after RPLY_DESKEW cycles, rdata<=ZDAL[15:0], negate TDIN, go to RNEG.
- WSETUP: after DATA_SETUP cycles, assert TDOUT and go to WWAIT.
- WWAIT: on RRPLY wait RPLY_DESKEW cycles, negate TDOUT, go to WHOLD. Timeout goes to ABORT.
- WHOLD: after DATA_HOLD cycles, release DAL (DALtx=0, DALbe_L=1, ZWTBT=0) and go to RNEG.
- RNEG: wait for RRPLY=0, then negate TSYNC and go to DONE. If RRPLY is still high after TIMEOUT, negate TSYNC anyway and go to DONE; nxm stays 0.
- ABORT: negate TDIN/TDOUT, release DAL, negate TSYNC. nxm=1. Go to DONE.
- DONE: done=1 for one cycle, busy=0. Return to IDLE.
- Timeout counter: $clog2(TIMEOUT+1) bits. Cleared on each state entry; saturates.
- An RRPLY already high when TDIN/TDOUT asserts counts as a reply.

Decomposition:
- qbus_pkg holds the state enum and default timing constants, shared with the future DMA controller and bench.
- Sub-module qbus_delay: a loadable down-counter with a zero flag, used for all setup/hold/deskew/timeout counts.

Test Plan:
- DATI 777570, bs7=1; bench slave asserts RPLY with DAL=177777 -> TSYNC exactly 3 cycles after ZDAL valid; rdata=177777; done with nxm=0; TSYNC drops only after RPLY negates.
- DATO 000440=054321; slave latches on DOUT -> slave sees 054321; ZWTBT=1 in the address phase and 0 in the data phase; TDOUT asserted 2 cycles after data; done, nxm=0.
- DATOB 000441=000252, byte=1 -> ZWTBT=1 in both phases; slave sees high-byte select.
- DATI 000400 with no slave -> nxm=1 after 200 cycles in RWAIT; TDIN and TSYNC negated; DAL released.
- RINIT pulsed during RWAIT -> all T* drop the next cycle; done with nxm=1; a following DATI 777570 succeeds.
- req pulsed during busy -> ignored; exactly one done; a back-to-back req in the cycle after done is accepted.
